stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 clock  input  1  system clock, 50 MHz; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 clock_dec  input  1  100 Hz square wave from the centisecond divider; asynchronous to this block's logic.
REQ-004 start_stop  input  1  debounced level from push button; each rising edge toggles run/pause.
REQ-005 clear  input  1  debounced level; each rising edge zeroes the time, honoured only when not RUNNING.
REQ-006 lap  input  1  debounced level; each rising edge toggles lap freeze, honoured only in RUNNING or LAP.
REQ-007 digits  output  24  display time as 6 BCD nibbles [23:0] = M1 M0 S1 S0 C1 C0 (minutes, seconds, centiseconds).
REQ-008 running  output  1  high in RUNNING and LAP.
REQ-009 overflow  output  1  one-clock pulse when time wraps from 59:59.99 to 00:00.00.

Function
REQ-010 clock_dec SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-clock tick, 3 clocks after the input edge.
REQ-011 start_stop, clear and lap SHALL each be rising-edge detected to one-clock pulses (registered previous value; no synchronizer beyond that).
REQ-012 FSM states: IDLE, RUNNING, PAUSED, LAP.
REQ-013 IDLE: start_stop pulse -> RUNNING; clear pulse -> stay IDLE, time zeroed; lap ignored.
REQ-014 RUNNING: start_stop -> PAUSED; lap -> LAP (display frozen at current time); clear ignored.
REQ-015 LAP: lap -> RUNNING (display resumes live time); start_stop -> PAUSED with display returning to live time; clear ignored.
REQ-016 PAUSED: start_stop -> RUNNING; clear -> IDLE with time zeroed; lap ignored.
REQ-017 Time counter SHALL advance by one centisecond per tick only in RUNNING or LAP.
REQ-018 Digit ranges: C0 0-9, C1 0-9, S0 0-9, S1 0-5, M0 0-9, M1 0-5; each digit wraps to 0 and carries to the next on the same tick.
REQ-019 At 59:59.99 a tick SHALL yield 00:00.00, assert overflow for that one clock, and remain in current state.
REQ-020 digits SHALL show the live counter except in LAP, where they SHALL hold the value captured on the clock the lap pulse was accepted.
REQ-021 Tick and button pulse on the same clock: the tick is applied using the pre-transition state (RUNNING->PAUSED still counts that tick; PAUSED->RUNNING does not).
REQ-022 Simultaneous start_stop and lap pulses: start_stop takes priority, lap is dropped.
REQ-023 Simultaneous start_stop and clear in PAUSED: clear takes priority (-> IDLE, zeroed).
REQ-024 digits and running SHALL be registered outputs; update one clock after the causing tick/pulse.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE, all digits 0 (digits = 24'h000000), lap capture 0, running 0, overflow 0, synchronizer and edge-detect flops 0.
REQ-026 Reset asserted mid-count SHALL discard the time; after release the block SHALL be in IDLE and ignore any clock_dec edge until started.
REQ-027 A button held high across reset release SHALL NOT generate a pulse.

Structure
REQ-028 Shared package stopwatch_pkg SHALL hold the state enum, the digit limit constants (9, 5) and the BCD digit width (4).
REQ-029 One sub-module bcd_digit: parameterized max value, inputs inc/clear, outputs 4-bit value and carry; instantiated six times in a carry chain.

Verification (tick driven by toggling clock_dec at reduced period)
REQ-030 Reset, start_stop, 100 ticks -> digits = 24'h000100, running = 1.
REQ-031 Preload via 359 999 ticks to 59:59.99, one more tick -> digits = 24'h000000, overflow high exactly one clock.
REQ-032 RUNNING at 00:00.42, lap, 10 ticks -> digits hold 24'h000042; lap again -> digits = 24'h000052.
REQ-033 Pause at 00:01.07, 5 ticks -> digits unchanged; clear -> 24'h000000, state IDLE, running = 0.
REQ-034 clear pulse in RUNNING at 00:00.30 -> ignored, count continues to 00:00.31 on next tick.
REQ-035 reset_n pulsed low at 00:12.34 while RUNNING -> digits = 24'h000000 asynchronously, ticks after release ignored.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch core
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_LAP     = 2'd3
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;

    localparam logic [DIGIT_W-1:0] MAX_NINE = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_FIVE = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit counter that wraps at MAX_VAL and carries
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX_VAL = MAX_NINE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               inc,
    input  logic               clear,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    // Carry is combinational so the whole chain advances on the same tick.
    assign carry = inc && (value == MAX_VAL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= carry ? '0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - MM:SS.CC stopwatch with run/pause/lap/clear control
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_dec,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] digits,
    output logic        running,
    output logic        overflow
);

    logic dec_meta;
    logic dec_sync;
    logic dec_prev;
    logic tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dec_meta <= 1'b0;
            dec_sync <= 1'b0;
            dec_prev <= 1'b0;
        end else begin
            dec_meta <= clock_dec;
            dec_sync <= dec_meta;
            dec_prev <= dec_sync;
        end
    end

    assign tick = dec_sync && !dec_prev;

    logic ss_prev;
    logic clr_prev;
    logic lap_prev;
    logic armed;
    logic ss_pulse;
    logic clr_pulse;
    logic lap_pulse;

    // armed masks the first clock after reset so a button held across release
    // is seen as already high rather than as a fresh edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ss_prev  <= 1'b0;
            clr_prev <= 1'b0;
            lap_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            ss_prev  <= start_stop;
            clr_prev <= clear;
            lap_prev <= lap;
            armed    <= 1'b1;
        end
    end

    assign ss_pulse  = armed && start_stop && !ss_prev;
    assign clr_pulse = armed && clear && !clr_prev;
    assign lap_pulse = armed && lap && !lap_prev;

    state_t state;
    state_t state_next;
    logic   capture;
    logic   clear_time;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        clear_time = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_pulse) clear_time = 1'b1;
                if (ss_pulse)  state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (ss_pulse) begin
                    state_next = ST_PAUSED;
                end else if (lap_pulse) begin
                    state_next = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (ss_pulse) begin
                    state_next = ST_PAUSED;
                end else if (lap_pulse) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                if (clr_pulse) begin
                    state_next = ST_IDLE;
                    clear_time = 1'b1;
                end else if (ss_pulse) begin
                    state_next = ST_RUNNING;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Ticks count against the state held before this clock's transition.
    logic counting;
    logic inc_c0;
    assign counting = (state == ST_RUNNING) || (state == ST_LAP);
    assign inc_c0   = tick && counting;

    logic [DIGIT_W-1:0] c0, c1, s0, s1, m0, m1;
    logic               cy_c0, cy_c1, cy_s0, cy_s1, cy_m0, cy_m1;

    bcd_digit #(.MAX_VAL(MAX_NINE)) u_c0 (
        .clock(clock), .reset_n(reset_n), .inc(inc_c0), .clear(clear_time),
        .value(c0), .carry(cy_c0)
    );
    bcd_digit #(.MAX_VAL(MAX_NINE)) u_c1 (
        .clock(clock), .reset_n(reset_n), .inc(cy_c0), .clear(clear_time),
        .value(c1), .carry(cy_c1)
    );
    bcd_digit #(.MAX_VAL(MAX_NINE)) u_s0 (
        .clock(clock), .reset_n(reset_n), .inc(cy_c1), .clear(clear_time),
        .value(s0), .carry(cy_s0)
    );
    bcd_digit #(.MAX_VAL(MAX_FIVE)) u_s1 (
        .clock(clock), .reset_n(reset_n), .inc(cy_s0), .clear(clear_time),
        .value(s1), .carry(cy_s1)
    );
    bcd_digit #(.MAX_VAL(MAX_NINE)) u_m0 (
        .clock(clock), .reset_n(reset_n), .inc(cy_s1), .clear(clear_time),
        .value(m0), .carry(cy_m0)
    );
    bcd_digit #(.MAX_VAL(MAX_FIVE)) u_m1 (
        .clock(clock), .reset_n(reset_n), .inc(cy_m0), .clear(clear_time),
        .value(m1), .carry(cy_m1)
    );

    logic [23:0] count;
    logic [23:0] lap_q;
    logic        running_q;
    logic        overflow_q;

    assign count = {m1, m0, s1, s0, c1, c0};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            lap_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_next;
            running_q  <= (state_next == ST_RUNNING) || (state_next == ST_LAP);
            overflow_q <= cy_m1;
            if (capture) lap_q <= count;
        end
    end

    // All mux inputs are flops, so the display changes one clock after its cause.
    assign digits   = (state == ST_LAP) ? lap_q : count;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core
module tb_stopwatch_core;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        clock_dec  = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear      = 1'b0;
    logic        lap        = 1'b0;
    logic [23:0] digits;
    logic        running;
    logic        overflow;

    stopwatch_core dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clock_dec  (clock_dec),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digits     (digits),
        .running    (running),
        .overflow   (overflow)
    );

    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    // Model time is a plain centisecond count; BCD only appears when displayed.
    int cyc   = 0;
    int m_t   = 0;
    int m_st  = M_IDLE;
    int m_lap = 0;
    bit m_ovf = 0;
    bit p_ss  = 1;
    bit p_clr = 1;
    bit p_lap = 1;
    int tickq[$];

    function automatic logic [23:0] to_bcd(input int x);
        int m, s, c;
        m = x / 6000;
        s = (x / 100) % 60;
        c = x % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_t   = 0;
        m_st  = M_IDLE;
        m_lap = 0;
        m_ovf = 0;
        p_ss  = 1;
        p_clr = 1;
        p_lap = 1;
        tickq.delete();
    endtask

    task automatic model_edge();
        bit tk, ss, cl, lp;
        int old_t;
        cyc++;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tk = 0;
        while (tickq.size() > 0 && tickq[0] <= cyc) begin
            if (tickq[0] == cyc) tk = 1;
            void'(tickq.pop_front());
        end
        ss = start_stop && !p_ss;
        cl = clear && !p_clr;
        lp = lap && !p_lap;
        p_ss  = start_stop;
        p_clr = clear;
        p_lap = lap;
        old_t = m_t;
        m_ovf = 0;
        if (tk && (m_st == M_RUN || m_st == M_LAP)) begin
            if (m_t == 359999) begin
                m_t   = 0;
                m_ovf = 1;
            end else begin
                m_t++;
            end
        end
        case (m_st)
            M_IDLE: begin
                if (cl) m_t = 0;
                if (ss) m_st = M_RUN;
            end
            M_RUN: begin
                if (ss) m_st = M_PAUSE;
                else if (lp) begin
                    m_st  = M_LAP;
                    m_lap = old_t;
                end
            end
            M_LAP: begin
                if (ss) m_st = M_PAUSE;
                else if (lp) m_st = M_RUN;
            end
            default: begin
                if (cl) begin
                    m_st = M_IDLE;
                    m_t  = 0;
                end else if (ss) m_st = M_RUN;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("digits", digits, (m_st == M_LAP) ? to_bcd(m_lap) : to_bcd(m_t));
        chk("running", running, (m_st == M_RUN || m_st == M_LAP) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
    endtask

    // A rising clock_dec driven now is applied on the third following edge.
    task automatic drive_dec(input bit v);
        if (v && !clock_dec) tickq.push_back(cyc + 3);
        clock_dec = v;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive_dec(1);
            step();
            drive_dec(0);
            step();
        end
    endtask

    task automatic flush();
        repeat (4) step();
    endtask

    task automatic press(input bit b_ss, input bit b_clr, input bit b_lap);
        start_stop = b_ss;
        clear      = b_clr;
        lap        = b_lap;
        step();
        start_stop = 0;
        clear      = 0;
        lap        = 0;
        step();
    endtask

    task automatic tick_with_press(input bit b_ss);
        drive_dec(1);
        step();
        drive_dec(0);
        step();
        start_stop = b_ss;
        step();
        start_stop = 0;
        step();
    endtask

    task automatic do_reset();
        reset_n    = 0;
        start_stop = 0;
        clear      = 0;
        lap        = 0;
        drive_dec(0);
        step();
        step();
        reset_n = 1;
        step();
    endtask

    int ovf_cnt;

    initial begin
        start_stop = 1;
        #1;
        chk("rst_async_digits", digits, 24'h000000);
        step();
        step();
        chk("rst_digits", digits, 24'h000000);
        chk("rst_running", running, 0);
        chk("rst_overflow", overflow, 0);
        reset_n = 1;
        repeat (5) step();
        chk("held_button_no_start", running, 0);
        start_stop = 0;
        step();

        press(1, 0, 0);
        tick_n(100);
        flush();
        chk("count_100", digits, 24'h000100);
        chk("count_100_running", running, 1);

        tick_n(5900);
        flush();
        chk("minute_carry", digits, 24'h010000);

        dut.u_m1.value = 4'd5;
        dut.u_m0.value = 4'd9;
        dut.u_s1.value = 4'd5;
        dut.u_s0.value = 4'd9;
        dut.u_c1.value = 4'd9;
        dut.u_c0.value = 4'd9;
        m_t = 359999;
        #1;
        chk("preload", digits, 24'h595999);
        ovf_cnt = 0;
        drive_dec(1);
        step();
        ovf_cnt += int'(overflow);
        drive_dec(0);
        repeat (5) begin
            step();
            ovf_cnt += int'(overflow);
        end
        chk("wrap_digits", digits, 24'h000000);
        chk("wrap_ovf_pulses", ovf_cnt, 1);
        chk("wrap_still_running", running, 1);

        do_reset();
        press(1, 0, 0);
        tick_n(42);
        flush();
        press(0, 0, 1);
        tick_n(10);
        flush();
        chk("lap_hold", digits, 24'h000042);
        chk("lap_running", running, 1);
        press(0, 0, 1);
        chk("lap_release", digits, 24'h000052);

        tick_with_press(1);
        chk("tick_ss_run_counts", digits, 24'h000053);
        chk("tick_ss_paused", running, 0);
        tick_with_press(1);
        flush();
        chk("tick_ss_pause_no_count", digits, 24'h000053);
        chk("tick_ss_resumed", running, 1);
        press(1, 0, 1);
        chk("ss_lap_priority", running, 0);
        tick_n(3);
        flush();
        chk("ss_lap_digits", digits, 24'h000053);
        press(1, 1, 0);
        chk("ss_clr_priority", digits, 24'h000000);
        chk("ss_clr_idle", running, 0);

        press(1, 0, 0);
        tick_n(107);
        flush();
        press(1, 0, 0);
        tick_n(5);
        flush();
        chk("pause_hold", digits, 24'h000107);
        press(0, 1, 0);
        chk("pause_clear", digits, 24'h000000);
        chk("pause_clear_idle", running, 0);
        tick_n(3);
        flush();
        chk("idle_no_count", digits, 24'h000000);

        press(1, 0, 0);
        tick_n(30);
        flush();
        press(0, 1, 0);
        chk("clear_ignored_run", digits, 24'h000030);
        tick_n(1);
        flush();
        chk("clear_ignored_next", digits, 24'h000031);

        do_reset();
        press(1, 0, 0);
        tick_n(1234);
        flush();
        chk("pre_reset_count", digits, 24'h001234);
        @(posedge clock);
        model_edge();
        #3;
        reset_n = 0;
        drive_dec(0);
        model_reset();
        #1;
        chk("mid_reset_digits", digits, 24'h000000);
        chk("mid_reset_running", running, 0);
        @(negedge clock);
        reset_n = 1;
        tick_n(20);
        flush();
        chk("post_reset_digits", digits, 24'h000000);
        chk("post_reset_running", running, 0);

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 1) == 1) drive_dec(!clock_dec);
            if ($urandom_range(0, 15) == 0) start_stop = !start_stop;
            if ($urandom_range(0, 31) == 0) clear = !clear;
            if ($urandom_range(0, 23) == 0) lap = !lap;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
